medfilt_stream_tx: RTL and testbench
====================================

Name: medfilt_stream_tx

Overview:
Transmit-side feeder for the 3-tap median filter core. Accepts 8-bit signed samples from a host over a valid/ready handshake and buffers them in a small FIFO. Launches one sample per cycle onto the filter input bus, then captures the filter output in step with the filter pipeline. Presents only medians whose 3-sample window held real, consecutive samples; windows spanning stalls or reset fill are suppressed.

Parameters:
DW, 8, sample width; the filter treats samples as two's-complement signed
FIFO_DEPTH, 8, input FIFO entries; power of two, minimum 2
FLT_LATENCY, 2, edges from flt_inp change to the matching median on flt_utp

Ports:
clk  in  1  clock, shared with the filter core
rst_n  in  1  asynchronous active-low reset
s_data  in  DW  host sample
s_valid  in  1  host sample valid
s_ready  out  1  FIFO can accept a sample
tx_en  in  1  launch enable; 0 forces gap cycles
flt_inp  out  DW  registered sample to the filter input
flt_utp  in  DW  filter median output
m_data  out  DW  aligned median
m_valid  out  1  one-cycle strobe per valid median
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values (async, while rst_n=0): FIFO empty, fifo_level=0, flt_inp=0, m_data=0, m_valid=0, all tag and delay bits 0. s_ready=1 after reset.
- s_ready = (fifo_level < FIFO_DEPTH). It is combinational from the level and does not look ahead at pops.
- Push: on an edge with s_valid && s_ready.
- When full, s_ready=0, so a push is refused even if a pop happens in the same cycle.
- Launch: on an edge with tx_en && fifo_level>0, the head is popped into flt_inp and tag bit 1 is shifted in.
- Otherwise flt_inp holds its value and tag bit 0 is shifted in (gap cycle).
- A push into an empty FIFO cannot launch on the same edge. Launch happens at the earliest on the next edge (1-cycle fall-through).
- Simultaneous push and pop at non-full: the level is unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- Window valid: tag history is t0 (newest), t1, t2. win = t0&t1&t2, meaning three consecutive launches with no gap.
- win is delayed by a shift register of FLT_LATENCY stages.
- At the edge where the delayed win=1: m_data <= flt_utp and m_valid <= 1. Otherwise m_valid <= 0 and m_data holds.
- Latency: sample k popped at edge e; its median (k-2, k-1, k) appears with m_valid=1 after edge e+FLT_LATENCY+1.
- The first two samples after reset or after any gap produce no m_valid.
- No output backpressure; the consumer must accept every m_valid strobe.
- tx_en=0 mid-stream only inserts gaps; FIFO contents are preserved.
- rst_n asserted mid-operation discards the FIFO and every in-flight window.
- There is no m_valid after reset release until three new consecutive launches have occurred.
- Median ordering is signed (sign-extended compare inside the core). This block does no arithmetic on samples.

Optional Feature:
Macro MEDTX_GAP_CNT_EN.
- Defined: adds output gap_cnt (16 bits), reset to 0.
- gap_cnt increments on every edge where tx_en=1 and the FIFO is empty (an underrun gap). It saturates at 0xFFFF.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then push 10, 50, 30, 20 back-to-back with tx_en=1. Required: m_valid pulses exactly twice, on consecutive cycles, with m_data=30 then 30. The first pulse comes FLT_LATENCY+1 edges after 30 is popped.
- Signed ordering: push 0xFB (-5), 0x03, 0x64 (100). Required: a single m_valid with m_data=0x03.
- Gap: push 1, 2, 3, then hold tx_en=0 for 2 cycles, then push 4, 5, 6. Required: medians 2 and 5 only, with no pulse for windows spanning the gap.
- Full: hold tx_en=0 and offer 9 samples with FIFO_DEPTH=8. Required: s_ready drops after the 8th push, fifo_level=8, and the 9th sample is not accepted.
- Then raise tx_en. Required: the 9th sample is accepted 1 cycle after the first pop, all 8 original samples launch in order, and fifo_level returns to 0.
- Assert rst_n=0 mid-stream with 4 samples queued. Required: m_valid=0, fifo_level=0 and flt_inp=0 immediately (async). After release, 3 new samples yield exactly one median.
- With MEDTX_GAP_CNT_EN: tx_en=1 with an empty FIFO for 5 cycles. Required: gap_cnt=5.

Source files
------------

// File: rtl/medfilt_stream_tx_if.sv
// Host sample stream into the feeder and aligned median strobe out of it.
interface medfilt_stream_tx_if #(
   parameter int DW = 8
);
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;

   modport master (output s_data, s_valid, input s_ready, m_data, m_valid);
   modport slave  (input s_data, s_valid, output s_ready, m_data, m_valid);
endinterface

// File: rtl/medfilt_stream_tx.sv
// FIFO-fed launcher for the 3-tap median core; emits only medians of gap-free windows.
// Optional underrun counter output gap_cnt enabled by MEDTX_GAP_CNT_EN.
module medfilt_stream_tx #(
   parameter int DW          = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int FLT_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   medfilt_stream_tx_if.slave           bus,
   input  logic                         tx_en,
   output logic [DW-1:0]                flt_inp,
   input  logic [DW-1:0]                flt_utp,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef MEDTX_GAP_CNT_EN
   ,
   output logic [15:0]                  gap_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

   logic [DW-1:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic                   push, pop;
   logic [2:0]             tag;
   logic                   win;
   logic [FLT_LATENCY-1:0] win_dly;

   // s_ready ignores a same-cycle pop, so a full FIFO always refuses.
   assign bus.s_ready = (fifo_level < FULL_LVL);
   assign push        = bus.s_valid & bus.s_ready;
   assign pop         = tx_en & (fifo_level != '0);
   assign win         = &tag;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // tag[0] marks a real launch this edge; a gap shifts in 0 and holds flt_inp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_inp <= '0;
         tag     <= '0;
      end else begin
         tag <= {tag[1:0], pop};
         if (pop) flt_inp <= mem[rd_ptr];
      end
   end

   // win travels alongside the sample through the core's pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_dly     <= '0;
         bus.m_data  <= '0;
         bus.m_valid <= 1'b0;
      end else begin
         win_dly[0] <= win;
         for (int i = 1; i < FLT_LATENCY; i++) win_dly[i] <= win_dly[i-1];
         bus.m_valid <= win_dly[FLT_LATENCY-1];
         if (win_dly[FLT_LATENCY-1]) bus.m_data <= flt_utp;
      end
   end

`ifdef MEDTX_GAP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                              gap_cnt <= '0;
      else if (tx_en && fifo_level == '0 && gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_medfilt_stream_tx.sv
// Directed scoreboard bench for medfilt_stream_tx with a behavioural 3-tap median core.
module tb_medfilt_stream_tx;
   localparam int DW = 8, FIFO_DEPTH = 8, FLT_LATENCY = 2;

   logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0;
   logic [DW-1:0] flt_inp, flt_utp;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef MEDTX_GAP_CNT_EN
   logic [15:0] gap_cnt;
`endif

   medfilt_stream_tx_if #(.DW(DW)) bus ();

   medfilt_stream_tx #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .FLT_LATENCY(FLT_LATENCY)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .tx_en(tx_en),
      .flt_inp(flt_inp), .flt_utp(flt_utp), .fifo_level(fifo_level)
`ifdef MEDTX_GAP_CNT_EN
      , .gap_cnt(gap_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Median core model: window captured one edge after flt_inp, median one edge later.
   logic signed [DW-1:0] w0, w1, w2;
   function automatic logic [DW-1:0] med3(input logic signed [DW-1:0] a, b, c);
      if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
      if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
      return c;
   endfunction
   always @(posedge clk) begin
      w0 <= flt_inp; w1 <= w0; w2 <= w1;
      flt_utp <= med3(w0, w1, w2);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   logic [DW-1:0] exp_q[$];
   int pulse_cyc[$];
   logic [DW-1:0] e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.m_valid) begin
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_median: got %0h want none", bus.m_data);
         end else begin
            e = exp_q.pop_front();
            chk("median", {24'b0, bus.m_data}, {24'b0, e});
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [DW-1:0] d);
      logic rdy;
      int   n = 0;
      bus.s_valid = 1'b1; bus.s_data = d;
      do begin
         rdy = bus.s_ready;
         @(negedge clk);
         n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
         total++; bad++;
         $display("FAIL push_timeout: got not accepted want accepted");
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   int c0, p0, p1;

   initial begin
      bus.s_valid = 1'b0; bus.s_data = '0;
      idle(2);
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_flt_inp", flt_inp, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      rst_n = 1'b1;
      idle(1);

      // Basic window: 10,50,30,20 -> 30,30 on consecutive cycles
      tx_en = 1'b1;
      exp_q.push_back(8'd30); exp_q.push_back(8'd30);
      pulse_cyc.delete();
      c0 = cyc + 1;
      push(8'd10); push(8'd50); push(8'd30); push(8'd20);
      idle(10);
      chk("t1_pulse_count", pulse_cyc.size(), 2);
      p0 = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1;
      p1 = (pulse_cyc.size() > 1) ? pulse_cyc[1] : -1;
      chk("t1_first_latency", p0, c0 + 6);
      chk("t1_second_latency", p1, c0 + 7);

      // Signed ordering
      exp_q.push_back(8'h03);
      push(8'hFB); push(8'h03); push(8'h64);
      idle(10);

      // Gap splits windows
      exp_q.push_back(8'd2); exp_q.push_back(8'd5);
      push(8'd1); push(8'd2); push(8'd3);
      idle(2);
      tx_en = 1'b0; idle(2); tx_en = 1'b1;
      push(8'd4); push(8'd5); push(8'd6);
      idle(10);
      chk("t3_drained", exp_q.size(), 0);

      // Full FIFO refuses the 9th sample until a pop has freed a slot
      tx_en = 1'b0;
      for (int i = 0; i < 8; i++) push(8'(11 + i));
      chk("full_s_ready", bus.s_ready, 0);
      chk("full_level", fifo_level, 8);
      bus.s_valid = 1'b1; bus.s_data = 8'd19;
      idle(1);
      chk("full_refuse_level", fifo_level, 8);
      for (int i = 0; i < 7; i++) exp_q.push_back(8'(12 + i));
      tx_en = 1'b1;
      idle(1);
      chk("first_pop_level", fifo_level, 7);
      chk("first_pop_s_ready", bus.s_ready, 1);
      idle(1);
      chk("ninth_push_level", fifo_level, 7);
      bus.s_valid = 1'b0;
      idle(14);
      chk("drain_level", fifo_level, 0);
      chk("t4_drained", exp_q.size(), 0);

      // Async reset mid-stream discards queue and in-flight window
      tx_en = 1'b0;
      for (int i = 0; i < 7; i++) push(8'(40 + i));
      tx_en = 1'b1;
      idle(3);
      tx_en = 1'b0;
      chk("pre_rst_level", fifo_level, 4);
      chk("pre_rst_flt_inp", flt_inp, 42);
      #2 rst_n = 1'b0;
      #1;
      chk("async_m_valid", bus.m_valid, 0);
      chk("async_level", fifo_level, 0);
      chk("async_flt_inp", flt_inp, 0);
      chk("async_m_data", bus.m_data, 0);
      idle(2);
      rst_n = 1'b1;
      idle(4);
      chk("post_rst_level", fifo_level, 0);
      tx_en = 1'b1;
      exp_q.push_back(8'd60);
      push(8'd60); push(8'hFF); push(8'd61);
      idle(10);

`ifdef MEDTX_GAP_CNT_EN
      tx_en = 1'b0;
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      chk("gap_cnt_rst", gap_cnt, 0);
      tx_en = 1'b1;
      idle(5);
      tx_en = 1'b0;
      chk("gap_cnt_5", gap_cnt, 5);
      idle(2);
`endif

      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
